// File: rtl/axi_llc_flush_ctrl.sv
// LLC flush controller. Accepts a way-mask flush command, isolates the cache
// from new AXI traffic, walks every line of each selected way through the tag
// storage, forwards dirty lines to the eviction unit, waits for all evictions
// to complete, then records the flushed ways and releases isolation.

module axi_llc_flush_ctrl_chk #(
   parameter int unsigned CntWidth = 3
) (
   input logic                clk_i,
   input logic                rst_ni,
   input logic                evict_done_i,
   input logic [CntWidth-1:0] cnt_i
);
   // A completion with nothing outstanding means the eviction unit and this block disagree.
   a_done_has_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
      evict_done_i |-> (cnt_i != {CntWidth{1'b0}}));
endmodule

module axi_llc_flush_ctrl #(
   parameter int unsigned SetAssociativity = 8,
   parameter int unsigned NoLines          = 256,
   parameter int unsigned MaxEvict         = 4,
   parameter int unsigned IndexLength      = $clog2(NoLines)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        flush_valid_i,
   output logic                        flush_ready_o,
   input  logic [SetAssociativity-1:0] flush_ways_i,
   input  logic [SetAssociativity-1:0] spm_cfg_i,
   output logic [SetAssociativity-1:0] flushed_o,
   output logic                        busy_o,
   output logic                        isolate_o,
   input  logic                        isolated_i,
   output logic                        tag_req_valid_o,
   input  logic                        tag_req_ready_i,
   output logic [1:0]                  tag_req_mode_o,
   output logic [IndexLength-1:0]      tag_req_index_o,
   output logic [SetAssociativity-1:0] tag_req_way_o,
   input  logic                        tag_resp_valid_i,
   input  logic                        tag_resp_evict_i,
   output logic                        evict_valid_o,
   input  logic                        evict_ready_i,
   output logic [IndexLength-1:0]      evict_index_o,
   output logic [SetAssociativity-1:0] evict_way_o,
   input  logic                        evict_done_i
);

   localparam int unsigned CntWidth = $clog2(MaxEvict + 1);

   typedef enum logic [1:0] {
      TAG_BIST   = 2'b00,
      TAG_FLUSH  = 2'b01,
      TAG_LOOKUP = 2'b10,
      TAG_RSVD   = 2'b11
   } tag_req_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISOLATE = 3'd1,
      ST_REQ     = 3'd2,
      ST_RESP    = 3'd3,
      ST_EVICT   = 3'd4,
      ST_DRAIN   = 3'd5,
      ST_DONE    = 3'd6
   } state_e;

   localparam logic [IndexLength-1:0]      IdxZero = {IndexLength{1'b0}};
   localparam logic [IndexLength-1:0]      IdxOne  = IndexLength'(1);
   localparam logic [IndexLength-1:0]      IdxLast = IndexLength'(NoLines - 1);
   localparam logic [SetAssociativity-1:0] WayZero = {SetAssociativity{1'b0}};
   localparam logic [SetAssociativity-1:0] WayOne  = SetAssociativity'(1);
   localparam logic [CntWidth-1:0]         CntZero = {CntWidth{1'b0}};
   localparam logic [CntWidth-1:0]         CntOne  = CntWidth'(1);
   localparam logic [CntWidth-1:0]         CntMax  = CntWidth'(MaxEvict);

   // Isolate the lowest set bit of a way mask (one-hot result, zero if empty).
   function automatic logic [SetAssociativity-1:0] lowest_way(input logic [SetAssociativity-1:0] m);
      return m & (~m + WayOne);
   endfunction

   state_e                      state_q, state_d;
   logic [SetAssociativity-1:0] mask_q, mask_d;
   logic [SetAssociativity-1:0] way_q, way_d;
   logic [IndexLength-1:0]      index_q, index_d;
   logic [SetAssociativity-1:0] flushed_q, flushed_d;
   logic [CntWidth-1:0]         cnt_q, cnt_d;
   logic                        ready_q, ready_d;
   logic                        active_q, active_d;
   logic                        tag_valid_q, tag_valid_d;
   logic                        evict_valid_q, evict_valid_d;

   logic [SetAssociativity-1:0] accept_mask_s;
   logic [SetAssociativity-1:0] higher_ways_s;
   state_e                      adv_state_s;
   logic [IndexLength-1:0]      adv_index_s;
   logic [SetAssociativity-1:0] adv_way_s;
   logic                        evict_hs_s;

   // Effective command mask and the next line/way position of the walk.
   always_comb begin
      accept_mask_s = flush_ways_i & ~flushed_q;
      higher_ways_s = mask_q & ~(way_q | (way_q - WayOne));
      if (index_q != IdxLast) begin
         adv_state_s = ST_REQ;
         adv_index_s = index_q + IdxOne;
         adv_way_s   = way_q;
      end else if (higher_ways_s != WayZero) begin
         adv_state_s = ST_REQ;
         adv_index_s = IdxZero;
         adv_way_s   = lowest_way(higher_ways_s);
      end else begin
         adv_state_s = ST_DRAIN;
         adv_index_s = IdxZero;
         adv_way_s   = way_q;
      end
   end

   // Outstanding-eviction counter: +1 per descriptor handshake, -1 per completion.
   always_comb begin
      evict_hs_s = evict_valid_q & evict_ready_i;
      case ({evict_hs_s, evict_done_i})
         2'b10: cnt_d = cnt_q + CntOne;
         2'b01: begin
            if (cnt_q != CntZero) begin
               cnt_d = cnt_q - CntOne;
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: cnt_d = cnt_q;
      endcase
   end

   // Flush sequencer next-state logic.
   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      way_d     = way_q;
      index_d   = index_q;
      flushed_d = flushed_q;
      case (state_q)
         ST_IDLE: begin
            // Ways handed back to the cache lose their flushed status.
            flushed_d = flushed_q & spm_cfg_i;
            if (flush_valid_i && (accept_mask_s != WayZero)) begin
               mask_d  = accept_mask_s;
               way_d   = lowest_way(accept_mask_s);
               index_d = IdxZero;
               state_d = ST_ISOLATE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISOLATE: begin
            if (isolated_i) begin
               state_d = ST_REQ;
            end else begin
               state_d = ST_ISOLATE;
            end
         end
         ST_REQ: begin
            if (tag_req_ready_i) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_RESP: begin
            if (tag_resp_valid_i && tag_resp_evict_i) begin
               state_d = ST_EVICT;
            end else if (tag_resp_valid_i) begin
               state_d = adv_state_s;
               index_d = adv_index_s;
               way_d   = adv_way_s;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_EVICT: begin
            if (evict_hs_s) begin
               state_d = adv_state_s;
               index_d = adv_index_s;
               way_d   = adv_way_s;
            end else begin
               state_d = ST_EVICT;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == CntZero) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: begin
            flushed_d = flushed_q | mask_q;
            way_d     = WayZero;
            index_d   = IdxZero;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered handshake/status outputs, decoded from the next state.
   always_comb begin
      ready_d       = (state_d == ST_IDLE);
      active_d      = (state_d != ST_IDLE);
      tag_valid_d   = (state_d == ST_REQ);
      evict_valid_d = (state_d == ST_EVICT) && (cnt_d < CntMax);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_IDLE;
         mask_q        <= WayZero;
         way_q         <= WayZero;
         index_q       <= IdxZero;
         flushed_q     <= WayZero;
         cnt_q         <= CntZero;
         ready_q       <= 1'b1;
         active_q      <= 1'b0;
         tag_valid_q   <= 1'b0;
         evict_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         mask_q        <= mask_d;
         way_q         <= way_d;
         index_q       <= index_d;
         flushed_q     <= flushed_d;
         cnt_q         <= cnt_d;
         ready_q       <= ready_d;
         active_q      <= active_d;
         tag_valid_q   <= tag_valid_d;
         evict_valid_q <= evict_valid_d;
      end
   end

   assign flush_ready_o   = ready_q;
   assign busy_o          = active_q;
   assign isolate_o       = active_q;
   assign flushed_o       = flushed_q;
   assign tag_req_valid_o = tag_valid_q;
   assign tag_req_mode_o  = TAG_FLUSH;
   assign tag_req_index_o = index_q;
   assign tag_req_way_o   = way_q;
   assign evict_valid_o   = evict_valid_q;
   assign evict_index_o   = index_q;
   assign evict_way_o     = way_q;

   axi_llc_flush_ctrl_chk #(
      .CntWidth (CntWidth)
   ) i_chk (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .evict_done_i (evict_done_i),
      .cnt_i        (cnt_q)
   );

endmodule

// File: tb/tb_axi_llc_flush_ctrl.sv
// Bench for axi_llc_flush_ctrl: randomized tag-storage / eviction-unit
// responders and a transaction-level reference model of the flush walk.

module tb_axi_llc_flush_ctrl;
   localparam int SA = 4;
   localparam int NL = 4;
   localparam int ME = 4;
   localparam int IL = 2;

   logic          clk_i, rst_ni;
   logic          flush_valid_i, flush_ready_o;
   logic [SA-1:0] flush_ways_i, spm_cfg_i, flushed_o;
   logic          busy_o, isolate_o, isolated_i;
   logic          tag_req_valid_o, tag_req_ready_i;
   logic [1:0]    tag_req_mode_o;
   logic [IL-1:0] tag_req_index_o, evict_index_o;
   logic [SA-1:0] tag_req_way_o, evict_way_o;
   logic          tag_resp_valid_i, tag_resp_evict_i;
   logic          evict_valid_o, evict_ready_i, evict_done_i;

   axi_llc_flush_ctrl #(.SetAssociativity(SA), .NoLines(NL), .MaxEvict(ME)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o),
      .flush_ways_i(flush_ways_i), .spm_cfg_i(spm_cfg_i), .flushed_o(flushed_o),
      .busy_o(busy_o), .isolate_o(isolate_o), .isolated_i(isolated_i),
      .tag_req_valid_o(tag_req_valid_o), .tag_req_ready_i(tag_req_ready_i),
      .tag_req_mode_o(tag_req_mode_o), .tag_req_index_o(tag_req_index_o),
      .tag_req_way_o(tag_req_way_o), .tag_resp_valid_i(tag_resp_valid_i),
      .tag_resp_evict_i(tag_resp_evict_i), .evict_valid_o(evict_valid_o),
      .evict_ready_i(evict_ready_i), .evict_index_o(evict_index_o),
      .evict_way_o(evict_way_o), .evict_done_i(evict_done_i)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [SA-1:0] m_flushed;
   int            m_out;
   bit            dirty_a [SA][NL];
   int            exp_req_q[$];
   int            exp_ev_q[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      flush_valid_i    = 1'b0;
      isolated_i       = 1'b0;
      tag_req_ready_i  = 1'b0;
      tag_resp_valid_i = 1'b0;
      tag_resp_evict_i = 1'b0;
      evict_ready_i    = 1'b0;
      evict_done_i     = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_flushed"}, 32'(flushed_o), 32'd0);
      check_val({tag, "_status"}, 32'({flush_ready_o, busy_o, isolate_o}), 32'b100);
      check_val({tag, "_valids"}, 32'({tag_req_valid_o, evict_valid_o}), 32'd0);
      check_val({tag, "_pos"}, 32'({tag_req_way_o, tag_req_index_o}), 32'd0);
   endtask

   task automatic clear_flushed(input logic [SA-1:0] clr);
      @(negedge clk_i);
      spm_cfg_i = ~clr;
      @(negedge clk_i);
      spm_cfg_i = {SA{1'b1}};
      m_flushed = m_flushed & ~clr;
      check_val("spm_clear", 32'(flushed_o), 32'(m_flushed));
   endtask

   task automatic run_flush(input logic [SA-1:0] ways, input int dirty_pct, input int iso_dly,
                            input int done_hold, input int done_pct, input int rdy_pct,
                            input int abort_at);
      logic [SA-1:0] eff;
      int cyc, resp_tmr, resp_line, line;
      bit ev_wait, iso_given, finished;
      bit pv_t, pr_t, pv_e, pr_e;
      logic [SA+IL-1:0] pp_t, pp_e;
      @(negedge clk_i);
      check_val("cmd_ready", 32'(flush_ready_o), 32'd1);
      eff = ways & ~m_flushed;
      exp_req_q.delete();
      exp_ev_q.delete();
      for (int w = 0; w < SA; w++) begin
         if (eff[w]) begin
            for (int i = 0; i < NL; i++) begin
               dirty_a[w][i] = (int'($urandom_range(99, 0)) < dirty_pct);
               exp_req_q.push_back(w * NL + i);
               if (dirty_a[w][i]) exp_ev_q.push_back(w * NL + i);
            end
         end
      end
      flush_valid_i = 1'b1;
      flush_ways_i  = ways;
      @(negedge clk_i);
      flush_valid_i = 1'b0;
      flush_ways_i  = SA'($urandom);
      if (eff == '0) begin
         check_val("noop_status", 32'({busy_o, flush_ready_o}), 32'b01);
         check_val("noop_flushed", 32'(flushed_o), 32'(m_flushed));
         return;
      end
      check_val("accept_iso", 32'({busy_o, isolate_o, flush_ready_o}), 32'b110);
      resp_tmr = 0; resp_line = 0; ev_wait = 1'b0; iso_given = 1'b0; finished = 1'b0;
      pv_t = 1'b0; pr_t = 1'b0; pv_e = 1'b0; pr_e = 1'b0; pp_t = '0; pp_e = '0;
      cyc = 0;
      while (!finished && cyc < 3000) begin
         if (abort_at > 0 && cyc == abort_at) begin
            check_val("abort_busy", 32'(busy_o), 32'd1);
            #3 rst_ni = 1'b0;
            #1;
            check_reset_vals("async_rst");
            m_flushed = '0;
            m_out = 0;
            idle_inputs();
            @(negedge clk_i);
            rst_ni = 1'b1;
            return;
         end
         if (!busy_o) begin
            finished = 1'b1;
            m_flushed = m_flushed | eff;
            check_val("end_flushed", 32'(flushed_o), 32'(m_flushed));
            check_val("end_ready_iso", 32'({flush_ready_o, isolate_o}), 32'b10);
            check_val("end_outstanding", 32'(m_out), 32'd0);
            check_val("end_req_left", 32'(exp_req_q.size()), 32'd0);
            check_val("end_ev_left", 32'(exp_ev_q.size()), 32'd0);
         end else begin
            if (!iso_given) check_val("iso_wait", 32'({tag_req_valid_o, isolate_o}), 32'b01);
            if (tag_req_valid_o) check_val("req_mode", 32'(tag_req_mode_o), 32'b01);
            if (pv_t && !pr_t)
               check_val("req_hold", 32'({tag_req_valid_o, tag_req_way_o, tag_req_index_o}), 32'({1'b1, pp_t}));
            if (pv_e && !pr_e)
               check_val("ev_hold", 32'({evict_valid_o, evict_way_o, evict_index_o}), 32'({1'b1, pp_e}));
            check_val("ev_valid", 32'(evict_valid_o), ev_wait ? 32'(m_out < ME) : 32'd0);
            if (done_hold >= 40 && cyc == done_hold - 1)
               check_val("stall_count", 32'(m_out), 32'(ME));
            // responder stimulus for the coming edge
            isolated_i = (cyc >= iso_dly);
            if (isolated_i) iso_given = 1'b1;
            tag_req_ready_i  = (int'($urandom_range(99, 0)) < rdy_pct);
            evict_ready_i    = (int'($urandom_range(99, 0)) < rdy_pct);
            tag_resp_valid_i = 1'b0;
            tag_resp_evict_i = 1'b0;
            if (resp_tmr > 0) begin
               resp_tmr--;
               if (resp_tmr == 0) begin
                  tag_resp_valid_i = 1'b1;
                  tag_resp_evict_i = dirty_a[resp_line / NL][resp_line % NL];
                  if (tag_resp_evict_i) ev_wait = 1'b1;
               end
            end
            evict_done_i = (m_out > 0) && (cyc >= done_hold) &&
                           (int'($urandom_range(99, 0)) < done_pct);
            // events taking effect at the coming edge
            if (tag_req_valid_o && tag_req_ready_i) begin
               if (exp_req_q.size() == 0) begin
                  check_val("req_extra", 32'd1, 32'd0);
                  line = 0;
               end else begin
                  line = exp_req_q.pop_front();
                  check_val("req_way", 32'(tag_req_way_o), 32'd1 << (line / NL));
                  check_val("req_idx", 32'(tag_req_index_o), 32'(line % NL));
               end
               resp_line = line;
               resp_tmr  = int'($urandom_range(3, 1));
            end
            if (evict_valid_o && evict_ready_i) begin
               if (exp_ev_q.size() == 0) begin
                  check_val("ev_extra", 32'd1, 32'd0);
               end else begin
                  line = exp_ev_q.pop_front();
                  check_val("ev_line", 32'({evict_way_o, evict_index_o}),
                            ((32'd1 << (line / NL)) << IL) | 32'(line % NL));
               end
               m_out++;
               ev_wait = 1'b0;
            end
            if (evict_done_i) m_out--;
            pv_t = tag_req_valid_o; pr_t = tag_req_ready_i; pp_t = {tag_req_way_o, tag_req_index_o};
            pv_e = evict_valid_o;   pr_e = evict_ready_i;   pp_e = {evict_way_o, evict_index_o};
            @(negedge clk_i);
            cyc++;
         end
      end
      idle_inputs();
      if (!finished) begin
         check_val("timeout", 32'd0, 32'd1);
         rst_ni = 1'b0;
         @(negedge clk_i);
         rst_ni = 1'b1;
         m_flushed = '0;
         m_out = 0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      flush_ways_i = '0;
      spm_cfg_i    = {SA{1'b1}};
      m_flushed    = '0;
      m_out        = 0;
      rst_ni       = 1'b0;
      repeat (3) @(negedge clk_i);
      check_reset_vals("reset");
      rst_ni = 1'b1;
      @(negedge clk_i);
      check_reset_vals("post_reset");

      // all clean, consumers always ready
      run_flush(4'b0101, 0, 0, 0, 100, 100, 0);
      // return every way to the cache
      clear_flushed(4'b1111);
      // all dirty, completions held off until the walk stalls
      run_flush(4'b0101, 100, 0, 60, 100, 100, 0);
      clear_flushed(4'b1111);
      // isolation held off for 20 cycles
      run_flush(4'b0001, 50, 20, 0, 60, 70, 0);
      // way 0 already flushed: only way 1 walked
      run_flush(4'b0011, 50, 2, 0, 50, 60, 0);
      // nothing left to flush
      run_flush(4'b0001, 50, 0, 0, 50, 60, 0);
      // randomized sequences
      for (int k = 0; k < 5; k++) begin
         clear_flushed(SA'($urandom));
         run_flush(SA'($urandom), 60, int'($urandom_range(4, 0)), int'($urandom_range(10, 0)),
                   40, 60, 0);
      end
      // reset in the middle of a walk
      run_flush(4'b1111, 50, 0, 0, 50, 80, 9);
      @(negedge clk_i);
      check_reset_vals("after_abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
